sbd_cmt_ctrl: RTL
=================

# sbd_cmt_ctrl

In-order commit scheduler for the dual-issue pipeline. It records the execution pipeline chosen for each issued instruction in a circular scoreboard FIFO of `sbd_fifo_t` entries. It retires up to two instructions per cycle, in program order, as their pipelines report completion, and acknowledges the pipelines it consumed. It sits between the issue stage, which writes entries, and the commit/writeback stage, which consumes `cmt_*`.

## Interface
Parameters:
- `Depth`, default 8: number of scoreboard entries; must be a power of 2 and at least 4.
- `CntW`, default `$clog2(Depth+1)`: width of the occupancy count.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `issue_valid_i`, input, 2: issue slot valids. Slot 1 is valid only together with slot 0.
- `issue_entry_i`, input, 2 x `sbd_fifo_t`: per-slot `pl` (one-hot pipeline, 5 bits) and `pc`.
- `issue_ready_o`, output, 1: at least 2 entries are free.
- `pl_done_i`, input, 5: per-pipeline result valid. Each bit is held until acknowledged.
- `pl_ack_o`, output, 5: per-pipeline result consumed this cycle.
- `cmt_hold_i`, input, 1: blocks all commits this cycle.
- `flush_i`, input, 1: discards all entries.
- `cmt_valid_o`, output, 2: commit slot valids. Slot 1 is set only when slot 0 is set.
- `cmt_pl0_o`, `cmt_pl1_o`, output, 5 each: pipeline of each committed entry.
- `cmt_pc0_o`, `cmt_pc1_o`, output, 32 each: PC of each committed entry.
- `sbd_cnt_o`, output, `CntW`: occupancy.
- `sbd_empty_o`, output, 1: occupancy is 0.

## Operation
- **Storage and pointers**
  - Entry array of `Depth` x `sbd_fifo_t`.
  - Write pointer `wp` and read pointer `rp`, each `$clog2(Depth)` bits, wrapping modulo `Depth`.
  - Registered count `cnt`.
- **Issue**
  - An issue is accepted when `issue_ready_o` is 1 and `flush_i` is 0.
  - `nis = issue_valid_i[0] + issue_valid_i[1]` entries are written at `wp` and `wp+1`, and `wp` advances by `nis`.
  - `issue_ready_o = (Depth - cnt) >= 2`, computed from registered state only, with no same-cycle commit bypass.
- **Commit, head entry `H` at `rp`**
  - Slot 0 commits when `cnt >= 1`, `pl_done_i & H.pl` is nonzero, `cmt_hold_i` is 0, and `flush_i` is 0.
- **Commit, second entry `N` at `rp+1`**
  - Slot 1 commits when slot 0 commits, `cnt >= 2`, `pl_done_i & N.pl` is nonzero, and `N.pl != H.pl`.
  - The `N.pl != H.pl` condition exists because each pipeline delivers one result per cycle.
- **Outputs on commit**
  - `pl_ack_o` is the OR of the `pl` fields of the committed entries.
  - `cmt_pl*_o` and `cmt_pc*_o` carry the entry fields and are 0 when the corresponding slot is not valid.
  - `rp` advances by `ncm = cmt_valid_o[0] + cmt_valid_o[1]`.
- **Count update**
  - `cnt_next = cnt + nis - ncm`. Simultaneous issue and commit is legal, and the count never exceeds `Depth`.
- **Flush**
  - The next state is `wp = rp = 0` and `cnt = 0`.
  - Same-cycle issue is dropped.
  - Same-cycle `cmt_valid_o` and `pl_ack_o` are forced to 0.
- **Illegal inputs (assertions)**
  - Non-one-hot `pl` on a valid issue.
  - `issue_valid_i = 2'b10`.
  - Issue while `issue_ready_o` is 0.

## Timing
- **Reset values:** `wp = rp = cnt = 0`, `issue_ready_o = 1`, `sbd_empty_o = 1`, `sbd_cnt_o = 0`, `cmt_valid_o = 0`, `pl_ack_o = 0`, all `cmt_pl*`/`cmt_pc*` = 0. Entry contents are not reset.
- **Issue-to-commit latency:** an entry written in cycle T is first eligible for commit in cycle T+1.
- **Commit path:** combinational from `pl_done_i`, `cmt_hold_i` and `flush_i` to `cmt_*` and `pl_ack_o`. The pipeline drops `done` in the cycle after its ack.
- **Full condition:** with `cnt = Depth-1`, `issue_ready_o` is 0 even if a commit happens in the same cycle.
- **Wrap-around:** an issue at `wp = Depth-1` writes entries `Depth-1` and 0. A commit at `rp = Depth-1` examines `Depth-1` and 0.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous). Pending `pl_done_i` is not acknowledged.

## Structure
- `sbd_fifo_t` already exists in the shared package.
- A one-hot pipeline index constant set belongs in `super_pkg`: `PL_OH_ALU`, `PL_OH_LS`, `PL_OH_MULT`, `PL_OH_JAL`, `PL_OH_JALR`.
- One sub-module, `sbd_cmt_sel`: purely combinational eligibility and ack selection for the two head entries. The pointer, count and storage logic stay in the top module.

## Test plan
1. **Single entry:** reset, issue one entry with pl=ALU, pc=0x100, then assert ALU done the next cycle -> `cmt_valid_o = 01`, `cmt_pc0_o = 0x100`, `pl_ack_o = ALU`, cnt returns to 0.
2. **Dual commit:** issue pair (ALU, pc 0x200) and (LS, pc 0x204), both pipelines done -> `cmt_valid_o = 11`, `pl_ack_o = ALU|LS`, `rp += 2`.
3. **Ordering and same-pipeline limit:**
   - Pair (MULT, ALU) with only ALU done -> no commit.
   - Pair (ALU, ALU) with ALU done -> slot 0 only.
4. **Fill and wrap:**
   - Issue 8 entries with Depth=8 and no done -> `issue_ready_o = 0` at cnt=7.
   - Drain them, then issue across index 7 to 0 -> commits come out in order with correct PCs.
5. **Flush with concurrent activity:** cnt=5 with ALU done, plus `flush_i` and a pair issue in the same cycle -> `cmt_valid_o = 0`, `pl_ack_o = 0`, the next cycle has cnt=0 and `sbd_empty_o = 1`.
6. **Hold and asynchronous reset:** `cmt_hold_i = 1` with head done -> no commit, commit happens the cycle after the hold is released. `rst_i` asserted mid-cycle with cnt=3 -> outputs go to reset values immediately.

Source files
------------

// File: rtl/super_pkg.sv
// Shared pipeline types: one-hot execution pipeline ids and the scoreboard entry layout.
package super_pkg;

    localparam int PL_W = 5;

    typedef logic [PL_W-1:0] pl_oh_t;

    localparam pl_oh_t PL_OH_ALU  = 5'b00001;
    localparam pl_oh_t PL_OH_LS   = 5'b00010;
    localparam pl_oh_t PL_OH_MULT = 5'b00100;
    localparam pl_oh_t PL_OH_JAL  = 5'b01000;
    localparam pl_oh_t PL_OH_JALR = 5'b10000;

    typedef struct packed {
        pl_oh_t      pl;
        logic [31:0] pc;
    } sbd_fifo_t;

    function automatic logic pl_is_onehot(input pl_oh_t pl);
        return $onehot(pl);
    endfunction

endpackage

// File: rtl/sbd_cmt_ctrl_if.sv
// Issue, pipeline-completion and commit bundle of the commit scheduler.
// slave is the scheduler side, master is the surrounding pipeline side.
interface sbd_cmt_ctrl_if #(
    parameter int Depth = 8,
    parameter int CntW  = $clog2(Depth + 1)
) ();
    import super_pkg::*;

    logic [1:0]            issue_valid_i;
    sbd_fifo_t [1:0]       issue_entry_i;
    logic                  issue_ready_o;
    pl_oh_t                pl_done_i;
    pl_oh_t                pl_ack_o;
    logic                  cmt_hold_i;
    logic                  flush_i;
    logic [1:0]            cmt_valid_o;
    pl_oh_t                cmt_pl0_o;
    pl_oh_t                cmt_pl1_o;
    logic [31:0]           cmt_pc0_o;
    logic [31:0]           cmt_pc1_o;
    logic [CntW-1:0]       sbd_cnt_o;
    logic                  sbd_empty_o;

    modport slave (
        input  issue_valid_i, issue_entry_i, pl_done_i, cmt_hold_i, flush_i,
        output issue_ready_o, pl_ack_o, cmt_valid_o, cmt_pl0_o, cmt_pl1_o,
               cmt_pc0_o, cmt_pc1_o, sbd_cnt_o, sbd_empty_o
    );

    modport master (
        output issue_valid_i, issue_entry_i, pl_done_i, cmt_hold_i, flush_i,
        input  issue_ready_o, pl_ack_o, cmt_valid_o, cmt_pl0_o, cmt_pl1_o,
               cmt_pc0_o, cmt_pc1_o, sbd_cnt_o, sbd_empty_o
    );

endinterface

// File: rtl/sbd_cmt_sel.sv
// Commit eligibility of the two oldest scoreboard entries and the resulting pipeline acks.
// Purely combinational; slot 1 never commits alone or on the same pipeline as slot 0.
module sbd_cmt_sel
    import super_pkg::*;
(
    input  logic       cnt_ge1_i,
    input  logic       cnt_ge2_i,
    input  pl_oh_t     head_pl_i,
    input  pl_oh_t     next_pl_i,
    input  pl_oh_t     pl_done_i,
    input  logic       hold_i,
    input  logic       flush_i,
    output logic [1:0] cmt_vld_o,
    output pl_oh_t     pl_ack_o
);

    logic c0;
    logic c1;

    assign c0 = cnt_ge1_i & (|(pl_done_i & head_pl_i)) & ~hold_i & ~flush_i;
    // A pipeline returns one result per cycle, so two heads on one pipeline retire serially.
    assign c1 = c0 & cnt_ge2_i & (|(pl_done_i & next_pl_i)) & (next_pl_i != head_pl_i);

    assign cmt_vld_o = {c1, c0};
    assign pl_ack_o  = (c0 ? head_pl_i : '0) | (c1 ? next_pl_i : '0);

endmodule

// File: rtl/sbd_cmt_ctrl.sv
// In-order dual-issue / dual-commit scoreboard: a circular FIFO of issued entries retired
// as their pipelines report done. Commit outputs are combinational from done/hold/flush.
module sbd_cmt_ctrl
    import super_pkg::*;
#(
    parameter int Depth = 8,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sbd_cmt_ctrl_if.slave  bus
);

    localparam int PtrW = $clog2(Depth);

    sbd_fifo_t       mem_q [Depth];
    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            issue_rdy;
    logic            issue_acc;
    logic [1:0]      nis;
    logic [1:0]      ncm;
    logic [1:0]      cmt_vld;
    pl_oh_t          ack;
    sbd_fifo_t       head;
    sbd_fifo_t       nxt;
    logic [PtrW-1:0] wp_nxt;
    logic [PtrW-1:0] rp_nxt;

    // Ready looks only at the registered count, so a same-cycle commit never frees a slot.
    assign issue_rdy = (cnt_q <= CntW'(Depth - 2));
    assign issue_acc = issue_rdy & ~bus.flush_i;
    assign nis       = issue_acc ? ({1'b0, bus.issue_valid_i[0]} + {1'b0, bus.issue_valid_i[1]})
                                 : 2'd0;

    assign wp_nxt = wp_q + PtrW'(1);
    assign rp_nxt = rp_q + PtrW'(1);
    assign head   = mem_q[rp_q];
    assign nxt    = mem_q[rp_nxt];

    sbd_cmt_sel u_sel (
        .cnt_ge1_i (cnt_q != '0),
        .cnt_ge2_i (cnt_q >= CntW'(2)),
        .head_pl_i (head.pl),
        .next_pl_i (nxt.pl),
        .pl_done_i (bus.pl_done_i),
        .hold_i    (bus.cmt_hold_i),
        .flush_i   (bus.flush_i),
        .cmt_vld_o (cmt_vld),
        .pl_ack_o  (ack)
    );

    assign ncm = {1'b0, cmt_vld[0]} + {1'b0, cmt_vld[1]};

    always_comb begin
        wp_d  = wp_q + PtrW'(nis);
        rp_d  = rp_q + PtrW'(ncm);
        cnt_d = cnt_q + CntW'(nis) - CntW'(ncm);
        if (bus.flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (issue_acc && bus.issue_valid_i[0]) mem_q[wp_q]   <= bus.issue_entry_i[0];
        if (issue_acc && bus.issue_valid_i[1]) mem_q[wp_nxt] <= bus.issue_entry_i[1];
    end

    assign bus.issue_ready_o = issue_rdy;
    assign bus.cmt_valid_o   = cmt_vld;
    assign bus.pl_ack_o      = ack;
    assign bus.cmt_pl0_o     = cmt_vld[0] ? head.pl : '0;
    assign bus.cmt_pc0_o     = cmt_vld[0] ? head.pc : '0;
    assign bus.cmt_pl1_o     = cmt_vld[1] ? nxt.pl  : '0;
    assign bus.cmt_pc1_o     = cmt_vld[1] ? nxt.pc  : '0;
    assign bus.sbd_cnt_o     = cnt_q;
    assign bus.sbd_empty_o   = (cnt_q == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (bus.issue_valid_i[0]) assert (pl_is_onehot(bus.issue_entry_i[0].pl));
            if (bus.issue_valid_i[1]) assert (pl_is_onehot(bus.issue_entry_i[1].pl));
            assert (bus.issue_valid_i != 2'b10);
            assert (!bus.issue_valid_i[0] || issue_rdy);
        end
    end
`endif

endmodule
